cmd_packet_tx: RTL and testbench

//  Host-side packet builder for the serial-out command protocol. Accepts one parallel

---
 rtl/cmd_packet_tx.sv | 201 ++++++++++++++++++++
 tb/tb_cmd_packet_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_packet_tx.sv
// Host-side command packet serialiser feeding a UART TX byte handshake.
// Define PKT_CHECKSUM_EN to append an XOR checksum byte to every packet.
module cmd_packet_tx #(
  parameter int          DATA_BIT   = 32,
  parameter int          PACK_NUM   = 4,
  parameter logic [7:0]  CMD_DATA   = 8'h0B,
  parameter logic [7:0]  CMD_FREQ   = 8'h0A,
  parameter int          GAP_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_type_i,
  input  logic [DATA_BIT-1:0] req_pattern_i,
  input  logic [3:0]          req_channel_i,
  input  logic                req_mode_i,
  input  logic [7:0]          req_slow_i,
  input  logic [7:0]          req_fast_i,
  output logic                tx_start_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_done_tick_i,
  output logic                busy_o,
  output logic                pkt_done_tick_o
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP, DONE} state_t;

`ifdef PKT_CHECKSUM_EN
  localparam int CHK_LEN = 1;
`else
  localparam int CHK_LEN = 0;
`endif
  localparam logic [3:0] LAST_DATA = 4'(PACK_NUM + 1 + CHK_LEN);
  localparam logic [3:0] LAST_FREQ = 4'(PACK_NUM + 2 + CHK_LEN);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_t                state_r, state_nxt_s;
  logic [3:0]            byte_cnt_r, cnt_nxt_s;
  logic [7:0]            gap_cnt_r;
  logic                  type_r, mode_r;
  logic [DATA_BIT-1:0]   pattern_r;
  logic [3:0]            channel_r;
  logic [7:0]            slow_r, fast_r;
  logic                  tx_start_r, pkt_done_r, ready_r;
  logic [7:0]            tx_data_r;
  logic [7:0]            byte_s, chk_s;
  logic                  accept_s, last_s;

  // Byte at position idx of the packet described by the latched request fields.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic typ,
                                          input logic [DATA_BIT-1:0] pat, input logic [3:0] ch,
                                          input logic md, input logic [7:0] slow,
                                          input logic [7:0] fast, input logic [7:0] chk);
    logic [7:0] b;
    b = 8'h00;
    if (idx == 4'd0) begin
      b = typ ? CMD_FREQ : CMD_DATA;
    end else if (idx == 4'(PACK_NUM + 1)) begin
      b = typ ? slow : {ch, 1'b0, md, 2'b01};
    end else if (idx == 4'(PACK_NUM + 2)) begin
      b = typ ? fast : chk;
    end else if (idx == 4'(PACK_NUM + 3)) begin
      b = chk;
    end else begin
      for (int k = 0; k < PACK_NUM; k++) begin
        if (idx == 4'(k + 1)) begin
          b = pat[8*(PACK_NUM-1-k) +: 8];
        end else begin
          b = b;
        end
      end
    end
    return b;
  endfunction

  assign accept_s = (state_r == IDLE) && req_valid_i;
  assign last_s   = (byte_cnt_r == (type_r ? LAST_FREQ : LAST_DATA));

`ifdef PKT_CHECKSUM_EN
  logic [7:0] chk_r;

  // Running XOR of every byte already handed to the UART.
  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Checksum accumulator: cleared on accept, folded with each loaded byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_r <= 8'h00;
    end else if (accept_s) begin
      chk_r <= 8'h00;
    end else if (state_nxt_s == START) begin
      chk_r <= chk_next(chk_r, byte_s);
    end else begin
      chk_r <= chk_r;
    end
  end

  assign chk_s = chk_r;
`else
  assign chk_s = 8'h00;
`endif

  // Byte selected with the post-edge counter so tx_data matches the START cycle.
  assign byte_s = pkt_byte(cnt_nxt_s, type_r, pattern_r, channel_r, mode_r, slow_r, fast_r, chk_s);

  // Next-state and next byte-index logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = byte_cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 4'd0;
        if (req_valid_i) state_nxt_s = LOAD;
        else             state_nxt_s = IDLE;
      end
      LOAD:  state_nxt_s = START;
      START: state_nxt_s = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_done_tick_i) begin
          state_nxt_s = WAIT_DONE;
        end else if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = byte_cnt_r + 4'd1;
          if (GAP_CYCLES == 0) state_nxt_s = START;
          else                 state_nxt_s = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) state_nxt_s = START;
        else                       state_nxt_s = GAP;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, byte index and inter-byte gap counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      byte_cnt_r <= 4'd0;
      gap_cnt_r  <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      byte_cnt_r <= cnt_nxt_s;
      gap_cnt_r  <= (state_r == GAP) ? gap_cnt_r + 8'd1 : 8'd0;
    end
  end

  // Request capture; inputs are ignored once the packet is under way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_r    <= 1'b0;
      pattern_r <= '0;
      channel_r <= 4'd0;
      mode_r    <= 1'b0;
      slow_r    <= 8'h00;
      fast_r    <= 8'h00;
    end else if (accept_s) begin
      type_r    <= req_type_i;
      pattern_r <= req_pattern_i;
      channel_r <= req_channel_i;
      mode_r    <= req_mode_i;
      slow_r    <= req_slow_i;
      fast_r    <= req_fast_i;
    end else begin
      type_r    <= type_r;
      pattern_r <= pattern_r;
      channel_r <= channel_r;
      mode_r    <= mode_r;
      slow_r    <= slow_r;
      fast_r    <= fast_r;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      pkt_done_r <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      tx_start_r <= (state_nxt_s == START);
      tx_data_r  <= (state_nxt_s == START) ? byte_s : tx_data_r;
      pkt_done_r <= (state_nxt_s == DONE);
      ready_r    <= (state_nxt_s == IDLE);
    end
  end

  assign tx_start_o      = tx_start_r;
  assign tx_data_o       = tx_data_r;
  assign pkt_done_tick_o = pkt_done_r;
  assign req_ready_o     = ready_r;
  assign busy_o          = ~ready_r;

endmodule

// File: tb/tb_cmd_packet_tx.sv
// Directed bench for cmd_packet_tx with a fixed-latency UART TX model and a byte monitor.
module tb_cmd_packet_tx;
  localparam int GAP      = 3;
  localparam int DONE_DLY = 10;
  localparam int SPACING  = DONE_DLY + 1 + GAP;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_type_i = 1'b0;
  logic [31:0] req_pattern_i = 32'h0;
  logic [3:0]  req_channel_i = 4'h0;
  logic        req_mode_i = 1'b0;
  logic [7:0]  req_slow_i = 8'h00;
  logic [7:0]  req_fast_i = 8'h00;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_tick_i;
  logic        busy_o;
  logic        pkt_done_tick_o;

  logic [7:0]  tmr;
  logic        model_done;
  logic        spur_done = 1'b0;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          pkt_cnt = 0;
  logic [7:0]  bytes_q[$];
  logic [7:0]  exp_q[$];
  int          starts_q[$];
  int          done_q[$];

  cmd_packet_tx #(.GAP_CYCLES(GAP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_pattern_i(req_pattern_i),
    .req_channel_i(req_channel_i), .req_mode_i(req_mode_i),
    .req_slow_i(req_slow_i), .req_fast_i(req_fast_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_done_tick_i(tx_done_tick_i), .busy_o(busy_o),
    .pkt_done_tick_o(pkt_done_tick_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // UART TX model: done tick exactly DONE_DLY cycles after the tx_start cycle.
  assign tx_done_tick_i = model_done | spur_done;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr        <= 8'd0;
      model_done <= 1'b0;
    end else begin
      model_done <= (tmr == 8'd1);
      if (tx_start_o)       tmr <= 8'(DONE_DLY - 1);
      else if (tmr != 8'd0) tmr <= tmr - 8'd1;
    end
  end

  always @(negedge clk_i) begin
    if (tx_start_o) begin
      bytes_q.push_back(tx_data_o);
      starts_q.push_back(cyc);
    end
    if (pkt_done_tick_o) begin
      pkt_cnt = pkt_cnt + 1;
      done_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bytes_q.delete();
    starts_q.delete();
    done_q.delete();
    exp_q.delete();
    pkt_cnt = 0;
  endtask

  task automatic send(input logic typ, input logic [31:0] pat, input logic [3:0] ch,
                      input logic md, input logic [7:0] slow, input logic [7:0] fast,
                      output int hs);
    int t;
    t = 0;
    @(negedge clk_i);
    while (!req_ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    req_type_i = typ; req_pattern_i = pat; req_channel_i = ch;
    req_mode_i = md; req_slow_i = slow; req_fast_i = fast;
    req_valid_i = 1'b1;
    hs = cyc;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_pattern_i = 32'hDEADBEEF;
    req_channel_i = 4'h9;
    req_slow_i = 8'hEE;
    req_fast_i = 8'hDD;
  endtask

  task automatic wait_pkts(input int n, input string tag);
    int t;
    t = 0;
    while (pkt_cnt < n && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    repeat (3) @(negedge clk_i);
    chk(tag, 32'(pkt_cnt), 32'(n));
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_len"}, 32'(bytes_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(bytes_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < starts_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(starts_q[i] - starts_q[i-1]), 32'(SPACING));
  endtask

  initial begin
    int hs;
    int seen;
    int t;

    // 1: reset values while rst_ni is held low
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tx_start", 32'(tx_start_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'h00);
    chk("rst_pkt_done", 32'(pkt_done_tick_o), 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 2: data packet
    clr();
    exp_q = '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h35};
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'h3E);
`endif
    send(1'b0, 32'h55555555, 4'd3, 1'b1, 8'h00, 8'h00, hs);
    wait_pkts(1, "data_pkt_cnt");
    check_bytes("data");
    chk("first_start_latency", 32'((starts_q.size() > 0) ? starts_q[0] - hs : -1), 32'd2);
    check_spacing("data_spacing");

    // 3: frequency packet
    clr();
    exp_q = '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h14, 8'h05};
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'h5F);
`endif
    send(1'b1, 32'h11223344, 4'd0, 1'b0, 8'h14, 8'h05, hs);
    wait_pkts(1, "freq_pkt_cnt");
    check_bytes("freq");

    // 4: spurious done ticks in IDLE, START and GAP are ignored
    clr();
    exp_q = '{8'h0A, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h80, 8'h01};
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'h42);
`endif
    @(negedge clk_i); spur_done = 1'b1;
    @(negedge clk_i); spur_done = 1'b0;
    send(1'b1, 32'hCAFEF00D, 4'd0, 1'b0, 8'h80, 8'h01, hs);
    @(negedge clk_i);
    chk("spur_in_start", 32'(tx_start_o), 32'd1);
    spur_done = 1'b1;
    @(negedge clk_i); spur_done = 1'b0;
    t = 0;
    while (!model_done && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    @(negedge clk_i); spur_done = 1'b1;
    @(negedge clk_i); spur_done = 1'b0;
    wait_pkts(1, "spur_pkt_cnt");
    check_bytes("spur");
    check_spacing("spur_spacing");

    // 5: valid held across two packets, second accepted only after pkt_done
    clr();
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(8'h0B); exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
      exp_q.push_back(8'hC3); exp_q.push_back(8'hD4); exp_q.push_back(8'h71);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h7E);
`endif
    end
    @(negedge clk_i);
    req_type_i = 1'b0; req_pattern_i = 32'hA1B2C3D4; req_channel_i = 4'd7; req_mode_i = 1'b0;
    req_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("held_ready_low", 32'(req_ready_o), 32'd0);
    chk("held_busy_high", 32'(busy_o), 32'd1);
    seen = 0;
    t = 0;
    while (seen < 2 && t < 4000) begin
      @(negedge clk_i);
      t++;
      if (pkt_done_tick_o) begin
        seen++;
        if (seen == 2) req_valid_i = 1'b0;
      end
    end
    repeat (30) @(negedge clk_i);
    chk("held_pkt_cnt", 32'(pkt_cnt), 32'd2);
    check_bytes("held");
    chk("held_second_start",
        32'((done_q.size() > 0 && starts_q.size() > exp_q.size() / 2)
            ? starts_q[exp_q.size() / 2] - done_q[0] : -1), 32'd3);

    // 5b: all 16 channels, one-shot mode
    for (int ch = 0; ch < 16; ch++) begin
      clr();
      send(1'b0, 32'h0, 4'(ch), 1'b0, 8'h00, 8'h00, hs);
      wait_pkts(1, $sformatf("ch%0d_pkt_cnt", ch));
      chk($sformatf("ch%0d_ctrl", ch), 32'((bytes_q.size() > 5) ? bytes_q[5] : 8'hXX),
          32'({4'(ch), 4'h1}));
    end

    // 6: async reset mid-packet, then a full fresh packet
    clr();
    send(1'b1, 32'h11223344, 4'd0, 1'b0, 8'h14, 8'h05, hs);
    t = 0;
    while (bytes_q.size() < 3 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_tx_start", 32'(tx_start_o), 32'd0);
    chk("abort_tx_data", 32'(tx_data_o), 32'h00);
    chk("abort_pkt_done", 32'(pkt_done_tick_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    chk("abort_no_done", 32'(pkt_cnt), 32'd0);
    clr();
    exp_q = '{8'h0B, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'hFA);
`endif
    send(1'b0, 32'h01020304, 4'd15, 1'b1, 8'h00, 8'h00, hs);
    wait_pkts(1, "after_rst_pkt_cnt");
    check_bytes("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
